// File: rtl/mul_accumulate_if.sv
// Operand/result bundle for the shift-and-add multiply-accumulate unit.
// The requester drives operands and start; the unit returns product/valid/busy.
interface mul_accumulate_if #(
  parameter int QW = 8,
  parameter int DW = 7
);
  logic [QW-1:0]    quotientin;
  logic [DW-1:0]    divisorin;
  logic [DW-1:0]    remainderin;
  logic             start;
  logic [QW+DW-1:0] product;
  logic             valid;
  logic             busy;

  modport master (
    output quotientin, divisorin, remainderin, start,
    input  product, valid, busy
  );

  modport slave (
    input  quotientin, divisorin, remainderin, start,
    output product, valid, busy
  );
endinterface

// File: rtl/mul_accumulate.sv
// Sequential multiply-accumulate: product = quotient * divisor + remainder.
// One multiplier bit per cycle; result lands QW cycles after the accept edge.
module mul_accumulate #(
  parameter int QW = 8,
  parameter int DW = 7
) (
  input  logic            clk,
  input  logic            reset,
  mul_accumulate_if.slave bus
);
  localparam int PW = QW + DW;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [QW-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] product_q, product_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] sum;

  // Width is sized so that the accumulated sum can never carry out.
  assign sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          acc_d    = {{QW{1'b0}}, bus.remainderin};
          mcand_d  = {{QW{1'b0}}, bus.divisorin};
          mplier_d = bus.quotientin;
          cnt_d    = '0;
          valid_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last iteration publishes the sum including this cycle's partial product.
        if (cnt_q == LAST) begin
          product_d = sum;
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.product = product_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mul_accumulate.sv
// Bench for mul_accumulate: directed corner cases plus random operations,
// each checked cycle by cycle against q*d+r and the QW-cycle schedule.
module tb_mul_accumulate;
  localparam int QW = 8;
  localparam int DW = 7;
  localparam int PW = QW + DW;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [PW-1:0] prev_prod = '0;

  mul_accumulate_if #(.QW(QW), .DW(DW)) bus ();

  mul_accumulate #(.QW(QW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_cycles(input int n, input logic exp_v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_product", 32'(bus.product), 32'(prev_prod));
      chk("idle_valid", 32'(bus.valid), 32'(exp_v));
      chk("idle_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  // Called at a negedge before the intended accept edge. With chain set, start
  // stays high so the next operation (nq/nd/nr) is accepted on the first DONE edge.
  task automatic run_op(input int q, input int d, input int r, input bit noise,
                        input bit chain, input int nq, input int nd, input int nr);
    logic [PW-1:0] exp;
    exp = PW'(q * d + r);
    bus.start       = 1'b1;
    bus.quotientin  = QW'(q);
    bus.divisorin   = DW'(d);
    bus.remainderin = DW'(r);
    @(negedge clk);
    chk("accept_busy", 32'(bus.busy), 32'd1);
    chk("accept_valid", 32'(bus.valid), 32'd0);
    chk("accept_product_held", 32'(bus.product), 32'(prev_prod));
    if (chain) begin
      bus.quotientin  = QW'(nq);
      bus.divisorin   = DW'(nd);
      bus.remainderin = DW'(nr);
    end else begin
      bus.start       = 1'b0;
      bus.quotientin  = QW'($urandom);
      bus.divisorin   = DW'($urandom);
      bus.remainderin = DW'($urandom);
    end
    for (int k = 1; k <= QW; k++) begin
      @(negedge clk);
      if (k < QW) begin
        chk("run_busy", 32'(bus.busy), 32'd1);
        chk("run_valid", 32'(bus.valid), 32'd0);
        chk("run_product_held", 32'(bus.product), 32'(prev_prod));
        if (!chain) begin
          bus.start = noise && (k == 2 || k == 4);
          if (bus.start) begin
            bus.quotientin  = QW'($urandom);
            bus.divisorin   = DW'($urandom);
            bus.remainderin = DW'($urandom);
          end
        end
      end else begin
        chk("done_valid", 32'(bus.valid), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_product", 32'(bus.product), 32'(exp));
        if (!chain) bus.start = 1'b0;
      end
    end
    prev_prod = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.quotientin  = '0;
    bus.divisorin   = '0;
    bus.remainderin = '0;
    idle_cycles(2, 1'b0);
    reset = 1'b1;
    idle_cycles(20, 1'b0);

    // Nominal, then result held through idle cycles.
    run_op(200, 100, 57, 1'b0, 1'b0, 0, 0, 0);
    chk("nominal_value", 32'(prev_prod), 32'd20057);
    idle_cycles(10, 1'b1);

    // Extremes and zero operands.
    run_op(255, 127, 126, 1'b0, 1'b0, 0, 0, 0);
    idle_cycles(1, 1'b1);
    run_op(37, 0, 5, 1'b0, 1'b0, 0, 0, 0);
    idle_cycles(1, 1'b1);
    run_op(0, 99, 77, 1'b0, 1'b0, 0, 0, 0);
    idle_cycles(1, 1'b1);
    run_op(0, 0, 0, 1'b0, 1'b0, 0, 0, 0);
    idle_cycles(1, 1'b1);

    // start pulses during RUN must not restart or stretch the operation.
    run_op(13, 11, 3, 1'b1, 1'b0, 0, 0, 0);
    idle_cycles(2, 1'b1);

    // Back-to-back with start held high.
    run_op(10, 10, 0, 1'b0, 1'b1, 1, 1, 1);
    run_op(1, 1, 1, 1'b0, 1'b0, 0, 0, 0);
    idle_cycles(1, 1'b1);

    // Abort mid-operation with an asynchronous reset between edges.
    bus.start = 1'b1; bus.quotientin = 8'd255; bus.divisorin = 7'd127; bus.remainderin = 7'd127;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    prev_prod = '0;
    chk("async_rst_product", 32'(bus.product), 32'd0);
    chk("async_rst_valid", 32'(bus.valid), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(10, 1'b0);
    run_op(2, 3, 1, 1'b0, 1'b0, 0, 0, 0);
    idle_cycles(1, 1'b1);

    // Random operations with random spacing and occasional ignored starts.
    for (int i = 0; i < 30; i++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
             int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)), 1'b0, 0, 0, 0);
      idle_cycles(int'($urandom_range(0, 2)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
